// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle fetch path: next-PC selects,
// fetch FSM states and error codes.
package mips_pkg;

  typedef enum logic [1:0] {
    NPC_PLUS4 = 2'b00,
    NPC_BR    = 2'b01,
    NPC_J     = 2'b10,
    NPC_JR    = 2'b11
  } npcop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } fetch_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // Wide enough for MAX_WAIT up to 255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/mc_fetch_unit_if.sv
// Instruction memory request/response bus. The fetch unit is the master.
interface mc_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/mc_npc_calc.sv
// Combinational next-PC selection: pc+4, branch, jump, register jump.
module mc_npc_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       ir,
  input  logic [1:0]        npcop,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] rs_data,
  output logic [ADDR_W-1:0] npc
);

  // Keeps the PC bits above the 256 MB jump region; works for ADDR_W == 28.
  localparam logic [ADDR_W-1:0] REGION_MASK = ~ADDR_W'(28'hFFF_FFFF);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] j_tgt;

  // Candidate targets and selection; all arithmetic wraps at ADDR_W bits.
  always_comb begin
    pc_plus4 = pc + ADDR_W'(4);
    br_off   = {{(ADDR_W-18){ir[15]}}, ir[15:0], 2'b00};
    j_tgt    = (pc & REGION_MASK) | ADDR_W'({ir[25:0], 2'b00});
    npc      = pc_plus4;
    case (npcop_e'(npcop))
      NPC_PLUS4: npc = pc_plus4;
      NPC_BR:    npc = br_taken ? (pc + br_off) : pc_plus4;
      NPC_J:     npc = j_tgt;
      NPC_JR:    npc = rs_data;
      default:   npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/mc_fetch_unit.sv
// Multicycle fetch unit: PC, instruction register and a valid/ready
// instruction memory handshake with timeout and misalignment detection.
module mc_fetch_unit
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_3000),
  parameter int              MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              pc_wr,
  input  logic [1:0]        npcop,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] rs_data,
  mc_fetch_unit_if.master   imem,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic [1:0]        err_code
);

  // Last counter value at which the fetch may still complete.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] npc_d;
  logic [ADDR_W-1:0] addr_q;
  logic              req_valid_q;
  logic [DATA_W-1:0] ir_q;
  logic              ir_valid_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        code_q;
  logic [CNT_W-1:0]  cnt_q;

  mc_npc_calc #(
    .ADDR_W(ADDR_W)
  ) u_npc (
    .pc      (pc_q),
    .ir      (ir_q[31:0]),
    .npcop   (npcop),
    .br_taken(br_taken),
    .rs_data (rs_data),
    .npc     (npc_d)
  );

  // Fetch FSM, wait counter, PC and IR; all outputs are registered.
  // The counter runs from the first REQ cycle; a timeout on the same edge
  // as the handshake wins, while a response on the last cycle wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= '0;
      req_valid_q <= 1'b0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (pc_wr) begin
        pc_q <= npc_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (fetch_req) begin
            if (pc_q[1:0] != 2'b00) begin
              err_q  <= 1'b1;
              code_q <= ERR_MISALIGN;
            end else begin
              addr_q      <= pc_q;
              req_valid_q <= 1'b1;
              ir_valid_q  <= 1'b0;
              err_q       <= 1'b0;
              code_q      <= ERR_NONE;
              cnt_q       <= '0;
              state_q     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            req_valid_q <= 1'b0;
            ir_valid_q  <= 1'b0;
            err_q       <= 1'b1;
            code_q      <= ERR_TIMEOUT;
            state_q     <= ST_IDLE;
          end else if (imem.imem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (imem.imem_rsp_valid) begin
            ir_q       <= imem.imem_rsp_data[DATA_W-1:0];
            ir_valid_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            ir_valid_q <= 1'b0;
            err_q      <= 1'b1;
            code_q     <= ERR_TIMEOUT;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_addr      = addr_q;
  assign ir                  = ir_q;
  assign ir_valid            = ir_valid_q;
  assign pc                  = pc_q;
  assign busy                = (state_q != ST_IDLE);
  assign fetch_done          = done_q;
  assign fetch_err           = err_q;
  assign err_code            = code_q;

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Self-checking bench for mc_fetch_unit: next-PC vector table, hand-written
// corner sequences and randomized fetches against a transaction-level model.
module tb_mc_fetch_unit;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic        pc_wr;
  logic [1:0]  npcop;
  logic        br_taken;
  logic [31:0] rs_data;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] pc;
  logic        busy;
  logic        fetch_done;
  logic        fetch_err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  mc_fetch_unit_if #(.ADDR_W(32)) bus ();

  mc_fetch_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(32'h0000_3000),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .pc_wr     (pc_wr),
    .npcop     (npcop),
    .br_taken  (br_taken),
    .rs_data   (rs_data),
    .imem      (bus),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .busy      (busy),
    .fetch_done(fetch_done),
    .fetch_err (fetch_err),
    .err_code  (err_code)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  logic [31:0] m_pc, m_ir, m_addr;
  logic        m_irv, m_err;
  logic [1:0]  m_code;

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] ir_word;
    logic [1:0]  op;
    logic        br;
    logic [31:0] rs;
    logic [31:0] exp_pc;
  } npc_vec_t;

  npc_vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [31:0] i,
                                          input logic [1:0] op, input logic br,
                                          input logic [31:0] rs);
    int off;
    case (op)
      2'd0: return p + 32'd4;
      2'd1: begin
        off = int'($signed(i[15:0])) * 4;
        return br ? p + 32'(off) : p + 32'd4;
      end
      2'd2: return {p[31:28], i[25:0], 2'b00};
      default: return rs;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_ir = '0; m_addr = '0;
    m_irv = 1'b0; m_err = 1'b0; m_code = 2'b00;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, pc, 32'h0000_3000);
    chk({tag, "_ir"}, ir, 32'h0);
    chk({tag, "_irv"}, 32'(ir_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_reqv"}, 32'(bus.imem_req_valid), 32'd0);
    chk({tag, "_addr"}, bus.imem_addr, 32'h0);
    chk({tag, "_done"}, 32'(fetch_done), 32'd0);
    chk({tag, "_err"}, 32'(fetch_err), 32'd0);
    chk({tag, "_code"}, 32'(err_code), 32'd0);
  endtask

  task automatic pcwr(input logic [1:0] op, input logic br, input logic [31:0] rs);
    @(negedge clk);
    pc_wr = 1'b1; npcop = op; br_taken = br; rs_data = rs;
    m_pc = ref_npc(m_pc, m_ir, op, br, rs);
    @(negedge clk);
    pc_wr = 1'b0;
    chk("pc_update", pc, m_pc);
  endtask

  // One fetch: ready comes dr cycles after the first REQ cycle, response ds
  // cycles after entering WAIT; stray drives rsp_valid during REQ.
  // The fetch completes iff it spends at most MAXW cycles in REQ+WAIT.
  task automatic do_fetch(input int dr, input int ds, input bit stray, input logic [31:0] word);
    bit ok, exp_req, exp_busy;
    int last;
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    if (m_pc[1:0] != 2'b00) begin
      m_err = 1'b1; m_code = 2'b01;
      chk("mis_busy", 32'(busy), 32'd0);
      chk("mis_reqv", 32'(bus.imem_req_valid), 32'd0);
      chk("mis_err", 32'(fetch_err), 32'(m_err));
      chk("mis_code", 32'(err_code), 32'(m_code));
      return;
    end
    m_addr = m_pc;
    ok = (dr + ds + 2 <= MAXW);
    last = dr + ds + 1;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      exp_req  = (k <= dr) && (k < MAXW);
      exp_busy = ok || (k < MAXW);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
      if (exp_req) chk("req_addr", bus.imem_addr, m_addr);
      bus.imem_req_ready = (k == dr);
      bus.imem_rsp_valid = (k == last) || (stray && k <= dr);
      bus.imem_rsp_data  = (k == last) ? word : $urandom;
    end
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    if (ok) begin
      m_ir = word; m_irv = 1'b1; m_err = 1'b0; m_code = 2'b00;
    end else begin
      m_irv = 1'b0; m_err = 1'b1; m_code = 2'b10;
    end
    chk("fetch_done", 32'(fetch_done), 32'(ok));
    chk("ir", ir, m_ir);
    chk("ir_valid", 32'(ir_valid), 32'(m_irv));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("busy_end", 32'(busy), 32'd0);
    if (ok) begin
      @(negedge clk);
      chk("done_pulse", 32'(fetch_done), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_3000, 32'h2008_0005, 2'd0, 1'b0, 32'h0,         32'h0000_3004};
    vecs[1] = '{32'h0000_3004, 32'h1000_FFFF, 2'd1, 1'b1, 32'h0,         32'h0000_3000};
    vecs[2] = '{32'h0000_3004, 32'h1000_FFFF, 2'd1, 1'b0, 32'h0,         32'h0000_3008};
    vecs[3] = '{32'h0000_3000, 32'h0800_0C10, 2'd2, 1'b0, 32'h0,         32'h0000_3040};
    vecs[4] = '{32'hA000_1000, 32'h0BFF_FFFF, 2'd2, 1'b0, 32'h0,         32'hAFFF_FFFC};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'd0, 1'b0, 32'h0,         32'h0000_0000};
    vecs[6] = '{32'h0000_3000, 32'h1000_0010, 2'd1, 1'b1, 32'h0,         32'h0000_3040};
    vecs[7] = '{32'h0000_0000, 32'h1000_FFFE, 2'd1, 1'b1, 32'h0,         32'hFFFF_FFF8};
    vecs[8] = '{32'h0000_3000, 32'h0000_0000, 2'd3, 1'b0, 32'h1234_5678, 32'h1234_5678};

    rst = 1'b0; fetch_req = 1'b0; pc_wr = 1'b0; npcop = 2'd0; br_taken = 1'b0; rs_data = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_reset_state("reset");

    // Minimum-latency fetch, then sequential PC.
    do_fetch(0, 0, 1'b0, 32'h2008_0005);
    pcwr(2'd0, 1'b0, 32'h0);
    chk("pc_plus4", pc, 32'h0000_3004);

    // Ready held low 4 cycles with a stray response during REQ.
    do_fetch(4, 1, 1'b1, 32'hCAFE_0001);

    // Timeout, followed by a stray response after the unit went idle.
    do_fetch(0, 16, 1'b0, 32'hDEAD_BEEF);
    chk("timeout_code", 32'(err_code), 32'd2);

    // Misaligned jr target, then a good one clears the error.
    pcwr(2'd3, 1'b0, 32'h0000_3006);
    do_fetch(0, 0, 1'b0, 32'h1111_2222);
    chk("misalign_code", 32'(err_code), 32'd1);
    pcwr(2'd3, 1'b0, 32'h0000_3008);
    do_fetch(1, 2, 1'b0, 32'h3333_4444);
    chk("err_cleared", 32'(fetch_err), 32'd0);

    // Next-PC vector table.
    for (int unsigned v = 0; v < 9; v++) begin
      pcwr(2'd3, 1'b0, vecs[v].start_pc);
      do_fetch(0, 0, 1'b0, vecs[v].ir_word);
      pcwr(vecs[v].op, vecs[v].br, vecs[v].rs);
      chk("tbl_pc", pc, vecs[v].exp_pc);
    end

    // pc_wr while in WAIT must not disturb the latched request address.
    pcwr(2'd3, 1'b0, 32'h0000_4000);
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0; bus.imem_req_ready = 1'b1;
    m_addr = m_pc;
    @(negedge clk); bus.imem_req_ready = 1'b0;
    pc_wr = 1'b1; npcop = 2'd0;
    m_pc = ref_npc(m_pc, m_ir, 2'd0, 1'b0, 32'h0);
    @(negedge clk); pc_wr = 1'b0;
    chk("wait_pcwr_pc", pc, m_pc);
    chk("wait_pcwr_addr", bus.imem_addr, m_addr);
    chk("wait_pcwr_busy", 32'(busy), 32'd1);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h5555_AAAA;
    @(negedge clk); bus.imem_rsp_valid = 1'b0;
    m_ir = 32'h5555_AAAA; m_irv = 1'b1; m_err = 1'b0; m_code = 2'b00;
    chk("wait_pcwr_ir", ir, m_ir);
    chk("wait_pcwr_done", 32'(fetch_done), 32'd1);

    // Reset in the middle of WAIT; a response during and after reset is dropped.
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0; bus.imem_req_ready = 1'b1;
    @(negedge clk); bus.imem_req_ready = 1'b0; rst = 1'b0;
    @(negedge clk);
    model_reset();
    chk_reset_state("midwait_rst");
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h7777_7777;
    rst = 1'b1;
    @(negedge clk); bus.imem_rsp_valid = 1'b0;
    chk("post_rst_ir", ir, 32'h0);
    chk("post_rst_irv", 32'(ir_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(fetch_done), 32'd0);

    // Randomized PC updates and fetches.
    for (int unsigned it = 0; it < 40; it++) begin
      logic [1:0]  op;
      logic [31:0] rs;
      op = 2'($urandom_range(0, 3));
      rs = $urandom;
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      pcwr(op, 1'($urandom_range(0, 1)), rs);
      do_fetch(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
               1'($urandom_range(0, 1)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_fetch_unit.md
Name: mc_fetch_unit

Overview:
Parametrised multicycle fetch unit. It owns the PC, the next-PC selection and the instruction register, and replaces the fixed-latency instruction memory path with a valid/ready request/response handshake. Adds a wait timeout, misalignment detection and a jr mode, none of which the previous fetch path had. It sits between the multicycle controller FSM and an instruction memory or bus of variable latency.

Parameters:
ADDR_W, 32, PC and address width (>=28).
DATA_W, 32, instruction width (fixed 32 for MIPS encoding; other values illegal).
RESET_PC, 32'h0000_3000, PC value after reset.
MAX_WAIT, 15, maximum cycles spent in REQ+WAIT before timeout (1..255).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low
fetch_req  in  1  start-fetch pulse from the controller
pc_wr  in  1  PC write enable
npcop  in  2  next-PC select: 00 pc+4, 01 branch, 10 jump, 11 jr
br_taken  in  1  branch condition (ALU zero, qualified by the controller)
rs_data  in  ADDR_W  jr target
imem_req_valid  out  1  request valid
imem_req_ready  in  1  request accepted
imem_addr  out  ADDR_W  request address, latched
imem_rsp_valid  in  1  response valid (no ready; the unit always accepts in WAIT)
imem_rsp_data  in  32  instruction word
ir  out  32  instruction register
ir_valid  out  1  ir holds the completed fetch
pc  out  ADDR_W  current PC
busy  out  1  state != IDLE
fetch_done  out  1  one-cycle pulse when ir is updated
fetch_err  out  1  sticky error flag
err_code  out  2  00 none, 01 misaligned, 10 timeout

Behaviour:
- Reset (rst==0 at a clock edge) forces the following, with priority over everything:
  - pc=RESET_PC, ir=0, ir_valid=0, imem_req_valid=0, imem_addr=0.
  - fetch_done=0, fetch_err=0, err_code=00, state=IDLE, wait counter=0.
  - An in-flight fetch is abandoned; responses arriving later are ignored.
- FSM states: IDLE, REQ, WAIT.
  - IDLE + fetch_req:
    - If pc[1:0]!=0: stay IDLE; set fetch_err=1, err_code=01; no request issued.
    - Otherwise: imem_addr<=pc, ir_valid<=0, fetch_err<=0, err_code<=00, counter<=0, go to REQ.
  - REQ: imem_req_valid=1 (registered output).
    - req_valid&&req_ready: go to WAIT.
    - Otherwise: hold valid and address stable.
  - WAIT: imem_req_valid=0.
    - imem_rsp_valid: ir<=imem_rsp_data, ir_valid<=1, fetch_done=1 for the next cycle, go to IDLE.
  - Timeout: the counter increments every cycle spent in REQ or WAIT. When it reaches MAX_WAIT without completion: go to IDLE, fetch_err=1, err_code=10, imem_req_valid dropped, ir unchanged and ir_valid=0.
- Latency:
  - fetch_req at cycle N gives imem_req_valid at N+1.
  - A response at cycle M gives ir/ir_valid/fetch_done at M+1.
  - Minimum is 3 cycles, with ready at N+1 and response at N+2.
- Responses are sampled only in WAIT. A response in the same cycle as the request handshake is not accepted.
- fetch_req while busy is ignored, with no queueing.
- PC update: on pc_wr, pc<=npc. This is legal in any state. The in-flight fetch uses the latched imem_addr and is unaffected.
- npc rules:
  - 00: pc+4.
  - 01: if br_taken, pc + (sext(ir[15:0])<<2); else pc+4.
  - 10: {pc[ADDR_W-1:28], ir[25:0], 2'b00}.
  - 11: rs_data.
  - All arithmetic is modulo 2^ADDR_W; 0xFFFF_FFFC+4 wraps to 0.
  - A misaligned jr target is accepted into pc and flagged at the next fetch_req.
- fetch_err is cleared only by an accepted fetch_req or by reset.

Decomposition:
- Shared package mips_pkg:
  - npcop encodings NPC_PLUS4/NPC_BR/NPC_J/NPC_JR.
  - Fetch state enum.
  - err_code constants.
- One combinational sub-module, mc_npc_calc: inputs pc, ir, npcop, br_taken, rs_data; output npc. Unit-testable on its own.
- FSM, counter and registers stay in mc_fetch_unit.

Test Plan:
- Release rst with pc checked -> pc=0x3000, ir=0, ir_valid=0, busy=0, imem_req_valid=0.
- fetch_req at pc=0x3000, ready at once, rsp 0x2008_0005 after 2 cycles -> imem_addr=0x3000; ir=0x2008_0005, ir_valid=1, one-cycle fetch_done pulse; pc_wr npcop=00 -> pc=0x3004.
- Ready held low 4 cycles -> imem_req_valid and imem_addr stable throughout; fetch completes normally. A rsp_valid asserted during REQ is ignored.
- No response with MAX_WAIT=15 -> at counter 15: fetch_err=1, err_code=10, ir_valid=0, busy=0. A later stray rsp leaves ir unchanged.
- pc_wr npcop=11 rs_data=0x3006, then fetch_req -> no request issued, err_code=01. Then pc_wr npcop=11 rs_data=0x3008 and fetch_req -> err cleared, fetch proceeds.
- Next-PC modes:
  - ir=0x1000_FFFF, pc=0x3004, br_taken=1, npcop=01 -> pc=0x3000.
  - npcop=10 with ir=0x0800_0C10 -> pc=0x0000_3040.
  - pc_wr during WAIT -> imem_addr unchanged.
  - rst low mid-WAIT -> every reset value restored.
